// File: rtl/instruction_fetch_queue_if.sv
// Fetch-queue bus: instruction-memory request/response channel plus the decode-side
// instruction handshake.
interface instruction_fetch_queue_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Sequential instruction fetcher: issues word requests under a credit limit, queues in-order
// responses with their PC, and drops stale responses after a redirect.
module instruction_fetch_queue #(
  parameter int unsigned Depth     = 4,
  parameter logic [31:0] ResetAddr = 32'h0000_0000
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             redirect_i,
  input  logic [31:0]                      redirect_pc_i,
  instruction_fetch_queue_if.master        fetch_io
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned SumW = CntW + 1;

  typedef enum logic [0:0] {StFetch, StFlush} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0] outst_q, outst_d;
  logic [CntW-1:0] stale_q, stale_d;
  logic [CntW-1:0] occ_q, occ_d;
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [63:0]     fifo_q [Depth];

  logic            req_valid;
  logic            inst_valid;
  logic            req_fire;
  logic            rsp_fire;
  logic            deq;
  logic            enq;
  logic [31:0]     redirect_base;
  logic [SumW-1:0] credits_used;
  logic            unused_pc_lsb;

  assign redirect_base = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  // Queued plus outstanding words never exceed Depth, so a response always has room.
  assign credits_used  = SumW'(occ_q) + SumW'(outst_q);
  assign req_fire      = req_valid & fetch_io.imem_req_ready;
  assign rsp_fire      = fetch_io.imem_rsp_valid;
  assign deq           = inst_valid & fetch_io.inst_ready;
  assign enq           = rsp_fire & (state_q == StFetch) & (stale_q == '0) & ~redirect_i;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    stale_d    = stale_q;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    outst_d    = outst_q + CntW'(req_fire) - CntW'(rsp_fire);
    if (redirect_i) begin
      // Everything still in flight after this edge belongs to the old path.
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      stale_d    = outst_d;
      occ_d      = '0;
      head_d     = '0;
      tail_d     = '0;
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (enq) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        tail_d   = tail_q + PtrW'(1);
      end
      if (deq) head_d = head_q + PtrW'(1);
      occ_d = occ_q + CntW'(enq) - CntW'(deq);
      if (rsp_fire && (stale_q != '0)) stale_d = stale_q - CntW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = (stale_d != '0) ? StFlush : StFetch;
    end else begin
      case (state_q)
        StFetch: state_d = StFetch;
        StFlush: if (stale_d == '0) state_d = StFetch;
        default: state_d = StFetch;
      endcase
    end
  end

  always_comb begin
    req_valid               = rst_ni & (state_q == StFetch) & (credits_used < SumW'(Depth));
    inst_valid              = rst_ni & (occ_q != '0);
    fetch_io.imem_req_valid = req_valid;
    fetch_io.imem_req_addr  = fetch_pc_q;
    fetch_io.inst_valid     = inst_valid;
    fetch_io.inst_data      = inst_valid ? fifo_q[head_q][63:32] : 32'h0;
    fetch_io.inst_pc        = inst_valid ? fifo_q[head_q][31:0] : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fetch_pc_q <= ResetAddr;
      rsp_pc_q   <= ResetAddr;
      outst_q    <= '0;
      stale_q    <= '0;
      occ_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      stale_q    <= stale_d;
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && enq) fifo_q[tail_q] <= {fetch_io.imem_rsp_data, rsp_pc_q};
  end

endmodule
